// File: rtl/alu_sched_pkg.sv
// Shared CPU definitions: ALU opcode encodings and scheduler FSM states.
package alu_sched_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_AND    = 5'b00001,
    OP_PASS_A = 5'b00010,
    OP_PASS_B = 5'b00011,
    OP_SUB    = 5'b01100,
    OP_INC    = 5'b10100
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

endpackage

// File: rtl/alu_sched_alu.sv
// Combinational 8-bit ALU with 9-bit internal result; carry is bit 8 (borrow for SUB).
module alu_sched_alu
  import alu_sched_pkg::*;
(
  input  logic [4:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] dout,
  output logic       carry,
  output logic       zero,
  output logic       err
);

  logic [8:0] res;

  always_comb begin
    res = '0;
    err = 1'b0;
    case (op)
      OP_ADD:    res = {1'b0, a} + {1'b0, b};
      OP_AND:    res = {1'b0, a & b};
      OP_PASS_A: res = {1'b0, a};
      OP_PASS_B: res = {1'b0, b};
      OP_SUB:    res = {1'b0, a} - {1'b0, b};
      OP_INC:    res = {1'b0, a} + 9'd1;
      default:   err = 1'b1;
    endcase
    dout  = res[7:0];
    carry = res[8];
    // Illegal opcodes report zero=0 even though the result is all zeros.
    zero  = !err && (res == '0);
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler sharing one ALU; one operation in flight,
// all outputs registered.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int PRIO_RESET = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_0,
  input  logic [4:0] op_0,
  input  logic [7:0] a_0,
  input  logic [7:0] b_0,
  output logic       gnt_0,
  output logic       rsp_valid_0,
  input  logic       rsp_ready_0,
  output logic [7:0] rsp_data_0,
  output logic       rsp_carry_0,
  output logic       rsp_zero_0,
  output logic       rsp_err_0,
  input  logic       req_1,
  input  logic [4:0] op_1,
  input  logic [7:0] a_1,
  input  logic [7:0] b_1,
  output logic       gnt_1,
  output logic       rsp_valid_1,
  input  logic       rsp_ready_1,
  output logic [7:0] rsp_data_1,
  output logic       rsp_carry_1,
  output logic       rsp_zero_1,
  output logic       rsp_err_1
);

  localparam logic PRIO_INIT = (PRIO_RESET != 0);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       prio_q, prio_d;
  logic [4:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0] data_q, data_d;
  logic       carry_q, carry_d, zero_q, zero_d, err_q, err_d;

  logic [7:0] alu_dout;
  logic       alu_carry, alu_zero, alu_err;
  logic       any_req, win, sel_ready, handshake;

  assign any_req   = req_0 | req_1;
  // prio_q names the requester that wins a tie; a lone request always wins.
  assign win       = (req_0 && req_1) ? prio_q : req_1;
  assign sel_ready = sel_q ? rsp_ready_1 : rsp_ready_0;
  assign handshake = rsp_valid_q[sel_q] && sel_ready;

  alu_sched_alu alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .dout  (alu_dout),
    .carry (alu_carry),
    .zero  (alu_zero),
    .err   (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (handshake) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_d       = sel_q;
    prio_d      = prio_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d[win] = 1'b1;
          sel_d      = win;
          prio_d     = ~win;
          op_d       = win ? op_1 : op_0;
          a_d        = win ? a_1  : a_0;
          b_d        = win ? b_1  : b_0;
        end
      end
      S_EXEC: begin
        data_d  = alu_dout;
        carry_d = alu_carry;
        zero_d  = alu_zero;
        err_d   = alu_err;
      end
      // Valid rises one cycle into RESP and drops on the edge that completes the handshake.
      S_RESP:  rsp_valid_d[sel_q] = ~handshake;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      prio_q      <= PRIO_INIT;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      data_q      <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      prio_q      <= prio_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign gnt_0       = gnt_q[0];
  assign gnt_1       = gnt_q[1];
  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_data_0  = data_q;
  assign rsp_data_1  = data_q;
  assign rsp_carry_0 = carry_q;
  assign rsp_carry_1 = carry_q;
  assign rsp_zero_0  = zero_q;
  assign rsp_zero_1  = zero_q;
  assign rsp_err_0   = err_q;
  assign rsp_err_1   = err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios plus randomized
// transactions against an arithmetic reference model.
module tb_alu_sched;

  logic       clk, rst_n;
  logic       req_0, req_1;
  logic [4:0] op_0, op_1;
  logic [7:0] a_0, b_0, a_1, b_1;
  logic       rsp_ready_0, rsp_ready_1;
  logic       gnt_0, gnt_1, rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_data_0, rsp_data_1;
  logic       rsp_carry_0, rsp_carry_1, rsp_zero_0, rsp_zero_1, rsp_err_0, rsp_err_1;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sched #(.PRIO_RESET(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .op_0(op_0), .a_0(a_0), .b_0(b_0), .gnt_0(gnt_0),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_data_0(rsp_data_0),
    .rsp_carry_0(rsp_carry_0), .rsp_zero_0(rsp_zero_0), .rsp_err_0(rsp_err_0),
    .req_1(req_1), .op_1(op_1), .a_1(a_1), .b_1(b_1), .gnt_1(gnt_1),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_data_1(rsp_data_1),
    .rsp_carry_1(rsp_carry_1), .rsp_zero_1(rsp_zero_1), .rsp_err_1(rsp_err_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: returns {err, zero, carry, data} from integer arithmetic.
  function automatic logic [10:0] model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    r = 0;
    case (op)
      5'd0:  r = int'(a) + int'(b);
      5'd1:  r = int'(a & b);
      5'd2:  r = int'(a);
      5'd3:  r = int'(b);
      5'd12: r = int'(a) - int'(b);
      5'd20: r = int'(a) + 1;
      default: return {1'b1, 1'b0, 1'b0, 8'h00};
    endcase
    return {1'b0, (r == 0), (r > 255 || r < 0), 8'(r & 255)};
  endfunction

  function automatic logic [25:0] all_outs();
    return {gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1,
            rsp_carry_0, rsp_carry_1, rsp_zero_0, rsp_zero_1, rsp_err_0, rsp_err_1};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one request and collects grant/response; no checking here.
  task automatic do_txn(input int who, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        output bit granted, output int lat, output logic [10:0] got, output bit other_seen);
    granted = 0; lat = -1; got = '0; other_seen = 0;
    @(negedge clk);
    if (who == 0) begin req_0 = 1'b1; op_0 = op; a_0 = a; b_0 = b; end
    else          begin req_1 = 1'b1; op_1 = op; a_1 = a; b_1 = b; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((who == 0) ? gnt_0 : gnt_1) begin granted = 1; break; end
    end
    if (who == 0) req_0 = 1'b0; else req_1 = 1'b0;
    if (granted) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if ((who == 0) ? rsp_valid_1 : rsp_valid_0) other_seen = 1;
        if ((who == 0) ? rsp_valid_0 : rsp_valid_1) begin
          lat = k;
          got = (who == 0) ? {rsp_err_0, rsp_zero_0, rsp_carry_0, rsp_data_0}
                           : {rsp_err_1, rsp_zero_1, rsp_carry_1, rsp_data_1};
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [25:0] v;
    rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    op_0 = '0; a_0 = '0; b_0 = '0; op_1 = '0; a_1 = '0; b_1 = '0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    repeat (2) @(negedge clk);
    v = all_outs();
    n_cmp++;
    if (v !== 26'd0) begin n_bad++; $display("FAIL reset_outputs: got %h expected %h", v, 26'd0); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    v = all_outs();
    n_cmp++;
    if (v !== 26'd0) begin n_bad++; $display("FAIL idle_after_reset: got %h expected %h", v, 26'd0); end
  endtask

  task automatic test_basic();
    bit g, o; int lat; logic [10:0] got;
    do_txn(0, 5'b00000, 8'h0F, 8'h01, g, lat, got, o);
    n_cmp++;
    if (g !== 1'b1) begin n_bad++; $display("FAIL basic_gnt: got %0b expected 1", g); end
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    n_cmp++;
    if (got !== 11'h010) begin n_bad++; $display("FAIL basic_result: got %h expected %h", got, 11'h010); end
    n_cmp++;
    if (o !== 1'b0) begin n_bad++; $display("FAIL basic_other_port: got %0b expected 0", o); end
  endtask

  task automatic test_flags();
    logic [4:0]  ops[3] = '{5'b00000, 5'b01100, 5'b01100};
    logic [7:0]  as[3]  = '{8'hFF, 8'h05, 8'h00};
    logic [7:0]  bs[3]  = '{8'h01, 8'h05, 8'h01};
    logic [10:0] exp[3] = '{11'h100, 11'h200, 11'h1FF};
    bit g, o; int lat; logic [10:0] got;
    for (int i = 0; i < 3; i++) begin
      do_txn(1, ops[i], as[i], bs[i], g, lat, got, o);
      n_cmp++;
      if (got !== exp[i] || g !== 1'b1)
        begin n_bad++; $display("FAIL flags_%0d: got %h gnt %0b expected %h", i, got, g, exp[i]); end
    end
  endtask

  task automatic test_illegal();
    bit g, o; int lat; logic [10:0] got;
    do_txn(0, 5'b00111, 8'h12, 8'h34, g, lat, got, o);
    n_cmp++;
    if (got !== 11'h400) begin n_bad++; $display("FAIL illegal_op: got %h expected %h", got, 11'h400); end
    do_txn(0, 5'b10100, 8'hFF, 8'h00, g, lat, got, o);
    n_cmp++;
    if (got !== 11'h100) begin n_bad++; $display("FAIL inc_wrap: got %h expected %h", got, 11'h100); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] order;
    int n_g, n_r0, n_r1;
    bit both_gnt, both_valid, bad_data;
    order = '0; n_g = 0; n_r0 = 0; n_r1 = 0;
    both_gnt = 0; both_valid = 0; bad_data = 0;
    apply_reset();
    req_0 = 1'b1; op_0 = 5'b00000; a_0 = 8'h01; b_0 = 8'h02;
    req_1 = 1'b1; op_1 = 5'b01100; a_1 = 8'h09; b_1 = 8'h04;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt_0 && gnt_1) both_gnt = 1;
      if ((gnt_0 || gnt_1) && n_g < 4) begin order[3 - n_g] = gnt_1; n_g++; end
      if (rsp_valid_0 && rsp_valid_1) both_valid = 1;
      if (rsp_valid_0) begin n_r0++; if (rsp_data_0 !== 8'h03) bad_data = 1; end
      if (rsp_valid_1) begin n_r1++; if (rsp_data_1 !== 8'h05) bad_data = 1; end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (order !== 4'b0101 || n_g != 4)
      begin n_bad++; $display("FAIL rr_order: got %b (%0d grants) expected 0101", order, n_g); end
    n_cmp++;
    if (both_gnt || both_valid)
      begin n_bad++; $display("FAIL rr_exclusive: got gnt %0b valid %0b expected 0 0", both_gnt, both_valid); end
    n_cmp++;
    if (bad_data || n_r0 < 2 || n_r1 < 2)
      begin n_bad++; $display("FAIL rr_data: got bad %0b r0 %0d r1 %0d expected 0 >=2 >=2", bad_data, n_r0, n_r1); end
  endtask

  task automatic test_backpressure();
    bit got_gnt0, unstable, early_gnt1, got_v, got_g1, got_v1;
    logic [7:0] d0, d1;
    int k1;
    got_gnt0 = 0; unstable = 0; early_gnt1 = 0; got_v = 0; got_g1 = 0; got_v1 = 0;
    d0 = '0; d1 = '0; k1 = -1;
    apply_reset();
    rsp_ready_0 = 1'b0;
    req_0 = 1'b1; op_0 = 5'b00000; a_0 = 8'h20; b_0 = 8'h22;
    req_1 = 1'b1; op_1 = 5'b00011; a_1 = 8'h11; b_1 = 8'h5A;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt_1) early_gnt1 = 1;
      if (gnt_0) begin got_gnt0 = 1; break; end
    end
    req_0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid_0) begin got_v = 1; break; end
      @(negedge clk);
      if (gnt_1) early_gnt1 = 1;
    end
    d0 = rsp_data_0;
    for (int k = 0; k < 5; k++) begin
      if (!rsp_valid_0 || rsp_data_0 !== d0) unstable = 1;
      if (gnt_1) early_gnt1 = 1;
      if (k < 4) @(negedge clk);
    end
    rsp_ready_0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (gnt_1) begin k1 = k; got_g1 = 1; break; end
    end
    req_1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid_1) begin got_v1 = 1; d1 = rsp_data_1; break; end
    end
    n_cmp++;
    if (!got_gnt0 || !got_v || d0 !== 8'h42)
      begin n_bad++; $display("FAIL bp_first: got gnt %0b valid %0b data %h expected 1 1 42", got_gnt0, got_v, d0); end
    n_cmp++;
    if (unstable) begin n_bad++; $display("FAIL bp_stable: got unstable %0b expected 0", unstable); end
    n_cmp++;
    if (early_gnt1) begin n_bad++; $display("FAIL bp_no_gnt1: got early gnt_1 %0b expected 0", early_gnt1); end
    n_cmp++;
    if (!got_g1 || k1 != 2) begin n_bad++; $display("FAIL bp_gnt1_timing: got %0d expected 2", k1); end
    n_cmp++;
    if (!got_v1 || d1 !== 8'h5A) begin n_bad++; $display("FAIL bp_resp1: got %h valid %0b expected 5a", d1, got_v1); end
  endtask

  task automatic test_reset_mid();
    bit g, o, got_gnt, stray, w0, w1; int lat; logic [10:0] got; logic [25:0] v;
    got_gnt = 0; stray = 0; w0 = 0; w1 = 0;
    do_txn(0, 5'b00000, 8'h30, 8'h03, g, lat, got, o);
    n_cmp++;
    if (got !== 11'h033) begin n_bad++; $display("FAIL pre_reset_txn: got %h expected %h", got, 11'h033); end
    @(negedge clk);
    req_0 = 1'b1; op_0 = 5'b00000; a_0 = 8'h01; b_0 = 8'h01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt_0) begin got_gnt = 1; break; end
    end
    req_0 = 1'b0;
    rst_n = 1'b0;
    #1;
    v = all_outs();
    n_cmp++;
    if (!got_gnt || v !== 26'd0) begin n_bad++; $display("FAIL reset_mid_outputs: got %h gnt %0b expected 0", v, got_gnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid_0 || rsp_valid_1) stray = 1;
    end
    n_cmp++;
    if (stray) begin n_bad++; $display("FAIL reset_mid_stray: got rsp_valid %0b expected 0", stray); end
    req_0 = 1'b1; req_1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt_0 || gnt_1) begin w0 = gnt_0; w1 = gnt_1; break; end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (w0 !== 1'b1 || w1 !== 1'b0)
      begin n_bad++; $display("FAIL reset_mid_prio: got gnt0 %0b gnt1 %0b expected 1 0", w0, w1); end
  endtask

  task automatic test_random();
    logic [4:0] legal[6] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100, 5'b10100};
    bit g, o; int lat, who; logic [10:0] got, exp;
    logic [4:0] op; logic [7:0] a, b;
    for (int i = 0; i < 30; i++) begin
      who = int'($urandom_range(0, 1));
      op  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal[$urandom_range(0, 5)];
      a   = 8'($urandom);
      b   = 8'($urandom);
      exp = model(op, a, b);
      do_txn(who, op, a, b, g, lat, got, o);
      n_cmp++;
      if (got !== exp || !g)
        begin n_bad++; $display("FAIL rand_%0d op %b a %h b %h port %0d: got %h expected %h", i, op, a, b, who, got, exp); end
      n_cmp++;
      if (lat != 2 || o)
        begin n_bad++; $display("FAIL rand_%0d_timing: got lat %0d other %0b expected 2 0", i, lat, o); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
